rr_mux_arbiter: RTL and testbench

RR_MUX_ARBITER -- requirements
Module: rr_mux_arbiter

---
 rtl/rr_mux_arbiter.sv | 171 +++++++++++++++++
 tb/tb_rr_mux_arbiter.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter with registered output mux.
// One requester at a time is granted; its data slot is captured into a
// registered output stage and held until the downstream handshake. On the
// handshake cycle the just-served requester is masked out, so another
// requester can be granted back to back with no bubble.
module rr_mux_arbiter #(
    parameter int SEL_WIDTH  = 2,
    parameter int DATA_WIDTH = 8
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic [(2**SEL_WIDTH)-1:0]                req,
    input  logic [((2**SEL_WIDTH)*DATA_WIDTH)-1:0]   in_data,
    input  logic                                     out_ready,
    output logic                                     out_valid,
    output logic [DATA_WIDTH-1:0]                    out_data,
    output logic [SEL_WIDTH-1:0]                     out_sel,
    output logic [(2**SEL_WIDTH)-1:0]                ack,
    output logic                                     busy,
    output logic [15:0]                              xfer_cnt
);

    localparam int NUM_REQ = 2**SEL_WIDTH;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t                  state_r;
    state_t                  state_s;
    logic                    out_valid_r;
    logic                    out_valid_s;
    logic [DATA_WIDTH-1:0]   out_data_r;
    logic [DATA_WIDTH-1:0]   out_data_s;
    logic [SEL_WIDTH-1:0]    out_sel_r;
    logic [SEL_WIDTH-1:0]    out_sel_s;
    logic [SEL_WIDTH-1:0]    last_r;
    logic [SEL_WIDTH-1:0]    last_s;
    logic [15:0]             xfer_cnt_r;
    logic [15:0]             xfer_cnt_s;
    logic                    handshake_s;
    logic [NUM_REQ-1:0]      eligible_s;
    logic [SEL_WIDTH-1:0]    winner_s;

    // First eligible index after 'last', wrapping modulo NUM_REQ. The
    // unsigned add of SEL_WIDTH bits provides the wrap for free; k == NUM_REQ
    // revisits 'last' itself as the lowest priority.
    function automatic logic [SEL_WIDTH-1:0] rr_pick(
        input logic [NUM_REQ-1:0]   elig,
        input logic [SEL_WIDTH-1:0] last
    );
        logic [SEL_WIDTH-1:0] idx;
        logic                 found;
        rr_pick = last;
        found   = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = last + SEL_WIDTH'(k);
            if (!found && elig[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end else begin
                found   = found;
            end
        end
    endfunction

    // Select one DATA_WIDTH slot out of the packed input bus.
    function automatic logic [DATA_WIDTH-1:0] slot_of(
        input logic [(NUM_REQ*DATA_WIDTH)-1:0] data,
        input logic [SEL_WIDTH-1:0]            idx
    );
        slot_of = {DATA_WIDTH{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            if (SEL_WIDTH'(i) == idx) begin
                slot_of = data[i*DATA_WIDTH +: DATA_WIDTH];
            end else begin
                slot_of = slot_of;
            end
        end
    endfunction

    // Handshake detection and the eligible set used for (re-)arbitration.
    always_comb begin
        handshake_s = (state_r == ST_BUSY) && out_valid_r && out_ready;
        eligible_s  = {NUM_REQ{1'b0}};
        case (state_r)
            ST_IDLE: eligible_s = req;
            ST_BUSY: begin
                if (handshake_s) begin
                    eligible_s = req & ~({{(NUM_REQ-1){1'b0}}, 1'b1} << out_sel_r);
                end else begin
                    eligible_s = {NUM_REQ{1'b0}};
                end
            end
            default: eligible_s = {NUM_REQ{1'b0}};
        endcase
        winner_s = rr_pick(eligible_s, last_r);
    end

    // Next-state and next-output computation for the two-state controller.
    always_comb begin
        state_s     = state_r;
        out_valid_s = out_valid_r;
        out_data_s  = out_data_r;
        out_sel_s   = out_sel_r;
        last_s      = last_r;
        xfer_cnt_s  = xfer_cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (|eligible_s) begin
                    state_s     = ST_BUSY;
                    out_valid_s = 1'b1;
                    out_sel_s   = winner_s;
                    out_data_s  = slot_of(in_data, winner_s);
                    last_s      = winner_s;
                end else begin
                    out_valid_s = 1'b0;
                end
            end
            ST_BUSY: begin
                if (handshake_s) begin
                    xfer_cnt_s = xfer_cnt_r + 16'd1;
                    if (|eligible_s) begin
                        out_valid_s = 1'b1;
                        out_sel_s   = winner_s;
                        out_data_s  = slot_of(in_data, winner_s);
                        last_s      = winner_s;
                    end else begin
                        state_s     = ST_IDLE;
                        out_valid_s = 1'b0;
                    end
                end else begin
                    state_s = ST_BUSY;
                end
            end
            default: begin
                state_s     = ST_IDLE;
                out_valid_s = 1'b0;
            end
        endcase
    end

    // State and output registers; reset discards any pending grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            out_valid_r <= 1'b0;
            out_data_r  <= {DATA_WIDTH{1'b0}};
            out_sel_r   <= {SEL_WIDTH{1'b0}};
            last_r      <= {SEL_WIDTH{1'b1}};
            xfer_cnt_r  <= 16'd0;
        end else begin
            state_r     <= state_s;
            out_valid_r <= out_valid_s;
            out_data_r  <= out_data_s;
            out_sel_r   <= out_sel_s;
            last_r      <= last_s;
            xfer_cnt_r  <= xfer_cnt_s;
        end
    end

    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_sel   = out_sel_r;
    assign busy      = (state_r == ST_BUSY);
    assign xfer_cnt  = xfer_cnt_r;
    assign ack       = handshake_s ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << out_sel_r)
                                   : {NUM_REQ{1'b0}};

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Scoreboard bench for rr_mux_arbiter (SEL_WIDTH=2, DATA_WIDTH=8).
// Inputs change on the falling edge. A transaction-level model predicts what
// the outputs must show during the coming half cycle and queues it; an
// independent monitor pops the queue and compares against the DUT.
module tb_rr_mux_arbiter;

    localparam int SW = 2;
    localparam int DW = 8;
    localparam int N  = 4;

    logic            clk;
    logic            rst_n;
    logic [N-1:0]    req;
    logic [N*DW-1:0] in_data;
    logic            out_ready;
    logic            out_valid;
    logic [DW-1:0]   out_data;
    logic [SW-1:0]   out_sel;
    logic [N-1:0]    ack;
    logic            busy;
    logic [15:0]     xfer_cnt;

    rr_mux_arbiter #(.SEL_WIDTH(SW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .in_data(in_data),
        .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
        .out_sel(out_sel), .ack(ack), .busy(busy), .xfer_cnt(xfer_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic          v;
        logic [DW-1:0] d;
        int            s;
        logic [15:0]   c;
        logic [N-1:0]  a;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;

    // Model state: a pending grant (or none), the last granted index, count.
    logic          m_pending;
    int            m_sel;
    logic [DW-1:0] m_data;
    int            m_last;
    logic [15:0]   m_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: predict this half cycle's outputs, then apply the
    // upcoming rising edge to the model state.
    always @(negedge clk) begin
        exp_t e;
        int   w;
        logic [N-1:0] elig;
        #2;
        if (!rst_n) begin
            m_pending = 1'b0; m_sel = 0; m_data = '0; m_last = N-1; m_cnt = 16'd0;
            e.v = 1'b0; e.d = '0; e.s = 0; e.c = 16'd0; e.a = '0;
            q.push_back(e);
        end else begin
            e.v = m_pending; e.d = m_data; e.s = m_sel; e.c = m_cnt;
            e.a = (m_pending && out_ready) ? N'(1 << m_sel) : '0;
            q.push_back(e);
            if (!(m_pending && !out_ready)) begin
                elig = req;
                if (m_pending) begin
                    m_cnt = m_cnt + 16'd1;
                    elig[m_sel] = 1'b0;
                end
                w = -1;
                for (int k = 1; k <= N; k++) begin
                    if (w < 0 && elig[(m_last + k) % N]) w = (m_last + k) % N;
                end
                if (w >= 0) begin
                    m_pending = 1'b1;
                    m_sel     = w;
                    m_data    = in_data[w*DW +: DW];
                    m_last    = w;
                end else begin
                    m_pending = 1'b0;
                end
            end
        end
    end

    // Monitor: compare the DUT against the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        #4;
        if (q.size() == 0) begin
            tests++; fails++;
            $display("FAIL scoreboard_empty at %0t", $time);
        end else begin
            e = q.pop_front();
            check("out_valid", 32'(out_valid), 32'(e.v));
            check("busy",      32'(busy),      32'(e.v));
            check("xfer_cnt",  32'(xfer_cnt),  32'(e.c));
            check("ack",       32'(ack),       32'(e.a));
            if (e.v) begin
                check("out_sel",  32'(out_sel),  32'(e.s));
                check("out_data", 32'(out_data), 32'(e.d));
            end else if (!rst_n) begin
                check("rst_out_sel",  32'(out_sel),  32'd0);
                check("rst_out_data", 32'(out_data), 32'd0);
            end
        end
    end

    task automatic step(input logic r, input logic [N-1:0] rq,
                        input logic [N*DW-1:0] d, input logic rdy);
        @(negedge clk);
        rst_n = r; req = rq; in_data = d; out_ready = rdy;
    endtask

    initial begin
        rst_n = 1'b0; req = '0; in_data = '0; out_ready = 1'b0;
        // Reset held with random inputs.
        for (int i = 0; i < 3; i++)
            step(1'b0, N'($urandom), (N*DW)'({$urandom, $urandom}), 1'($urandom));
        // Single request: slot2 = A5, ready high.
        step(1'b1, 4'b0000, 32'h0, 1'b1);
        step(1'b1, 4'b0100, 32'h00A5_0000, 1'b1);
        step(1'b1, 4'b0000, 32'h0, 1'b1);
        step(1'b1, 4'b0000, 32'h0, 1'b1);
        // Reset so requester 0 is first, then all request continuously.
        step(1'b0, 4'b0000, 32'h0, 1'b0);
        step(1'b1, 4'b0000, 32'h0, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b1, 4'b1111, 32'h4433_2211, 1'b1);
        step(1'b1, 4'b0000, 32'h0, 1'b0);
        step(1'b1, 4'b0000, 32'h0, 1'b0);
        // Grant to 1 stalled while its slot changes.
        step(1'b1, 4'b0010, 32'h0000_1100, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 4'b0000, 32'h0000_2200, 1'b0);
        step(1'b1, 4'b0000, 32'h0000_2200, 1'b1);
        step(1'b1, 4'b0000, 32'h0, 1'b1);
        // Single persistent requester: one grant per two cycles.
        for (int i = 0; i < 8; i++) step(1'b1, 4'b0010, 32'h0000_3C00, 1'b1);
        step(1'b1, 4'b0000, 32'h0, 1'b1);
        // Reset while a grant is stalled, then requester 3 alone.
        step(1'b1, 4'b0001, 32'h0000_005A, 1'b0);
        step(1'b1, 4'b0000, 32'h0, 1'b0);
        step(1'b0, 4'b0000, 32'h0, 1'b1);
        step(1'b0, 4'b1111, 32'hFFFF_FFFF, 1'b1);
        step(1'b1, 4'b1000, 32'h7700_0000, 1'b0);
        step(1'b1, 4'b0000, 32'h0, 1'b0);
        step(1'b1, 4'b0000, 32'h0, 1'b1);
        step(1'b1, 4'b0000, 32'h0, 1'b1);
        // Randomized traffic with occasional resets.
        for (int i = 0; i < 500; i++)
            step(($urandom_range(0, 63) != 0), N'($urandom),
                 (N*DW)'($urandom), ($urandom_range(0, 3) != 0));
        step(1'b1, 4'b0000, 32'h0, 1'b1);
        step(1'b1, 4'b0000, 32'h0, 1'b1);
        @(negedge clk);
        #6;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
